// File: rtl/amo_resp_unit_pkg.sv
// Shared types and constants for the cache-side AMO responder.
// Op encodings follow the LSU atomic-buffer request format.
package amo_resp_unit_pkg;

    localparam int unsigned PLEN_DEFAULT = 56;

    localparam logic [1:0]  SIZE_WORD   = 2'b10;
    localparam logic [1:0]  SIZE_DWORD  = 2'b11;
    localparam logic [63:0] AMO_SC_FAIL = 64'd1;

    typedef enum logic [3:0] {
        AMO_NONE = 4'b0000,
        AMO_LR   = 4'b0001,
        AMO_SC   = 4'b0010,
        AMO_SWAP = 4'b0011,
        AMO_ADD  = 4'b0100,
        AMO_AND  = 4'b0101,
        AMO_OR   = 4'b0110,
        AMO_XOR  = 4'b0111,
        AMO_MAX  = 4'b1000,
        AMO_MAXU = 4'b1001,
        AMO_MIN  = 4'b1010,
        AMO_MINU = 4'b1011,
        AMO_CAS1 = 4'b1101,
        AMO_CAS2 = 4'b1110
    } amo_op_e;

    typedef struct packed {
        logic        req;
        amo_op_e     amo_op;
        logic [1:0]  size;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        ACK     = 3'd4
    } amo_resp_state_e;

    // Ops that read memory first (LR reads without a write-back)
    function automatic logic is_read_op(amo_op_e op);
        case (op)
            AMO_LR, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
            AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU: is_read_op = 1'b1;
            default:                              is_read_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amo_resp_unit_if.sv
// AMO request/response, memory request/grant port and store snoop of the responder.
interface amo_resp_unit_if #(
    parameter int unsigned PLEN = amo_resp_unit_pkg::PLEN_DEFAULT
);
    import amo_resp_unit_pkg::*;

    amo_req_t         amo_req;
    amo_resp_t        amo_resp;
    logic             mem_req;
    logic             mem_gnt;
    logic             mem_we;
    logic [PLEN-1:0]  mem_addr;
    logic [7:0]       mem_be;
    logic [63:0]      mem_wdata;
    logic             mem_rvalid;
    logic [63:0]      mem_rdata;
    logic             snoop_valid;
    logic [PLEN-1:0]  snoop_addr;

    // master: LSU / memory / snoop side driving the responder
    modport master (
        output amo_req, mem_gnt, mem_rvalid, mem_rdata, snoop_valid, snoop_addr,
        input  amo_resp, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  amo_req, mem_gnt, mem_rvalid, mem_rdata, snoop_valid, snoop_addr,
        output amo_resp, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/amo_resp_unit_alu.sv
// Combinational AMO arithmetic: new memory value from old value and operand.
module amo_alu
    import amo_resp_unit_pkg::*;
(
    input  amo_op_e     op,
    input  logic [1:0]  size,
    input  logic [63:0] old_val,
    input  logic [63:0] operand,
    output logic [63:0] new_val
);

    logic        dword;
    logic [63:0] a;
    logic [63:0] b;
    logic        lt_s;
    logic        lt_u;
    logic [63:0] r;

    assign dword = (size == SIZE_DWORD);

    // Sign-extending words to 64 bits keeps both signed and unsigned ordering intact
    assign a = dword ? old_val : {{32{old_val[31]}}, old_val[31:0]};
    assign b = dword ? operand : {{32{operand[31]}}, operand[31:0]};

    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        r = b;
        case (op)
            AMO_ADD:  r = a + b;
            AMO_AND:  r = a & b;
            AMO_OR:   r = a | b;
            AMO_XOR:  r = a ^ b;
            AMO_MAX:  r = lt_s ? b : a;
            AMO_MAXU: r = lt_u ? b : a;
            AMO_MIN:  r = lt_s ? a : b;
            AMO_MINU: r = lt_u ? a : b;
            default:  r = b;
        endcase
    end

    assign new_val = dword ? r : {r[31:0], r[31:0]};

endmodule

// File: rtl/amo_resp_unit.sv
// AMO responder: read-modify-write over a request/grant memory port with one
// LR/SC reservation; returns the old value or SC status on the response.
module amo_resp_unit
    import amo_resp_unit_pkg::*;
#(
    parameter int unsigned PLEN    = PLEN_DEFAULT,
    parameter int unsigned RSV_LSB = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    amo_resp_unit_if.slave bus
);

    amo_resp_state_e        state_reg,     state_next;
    amo_op_e                op_reg,        op_next;
    logic [1:0]             size_reg,      size_next;
    logic [PLEN-1:0]        addr_reg,      addr_next;
    logic [63:0]            operand_reg,   operand_next;
    logic [63:0]            wdata_reg,     wdata_next;
    logic [63:0]            pending_reg,   pending_next;
    logic [63:0]            result_reg,    result_next;
    logic                   rsv_valid_reg, rsv_valid_next;
    logic [PLEN-1:RSV_LSB]  rsv_addr_reg,  rsv_addr_next;

    amo_req_t        req;
    logic            req_dword;
    logic [PLEN-1:0] req_addr;
    logic            rsv_hit;
    logic            dword;
    logic [31:0]     old_word;
    logic [63:0]     old_val;
    logic [63:0]     alu_val;
    logic            unused_bits;

    assign req       = bus.amo_req;
    assign req_dword = (req.size == SIZE_DWORD);
    assign req_addr  = req.operand_a[PLEN-1:0];
    assign rsv_hit   = rsv_valid_reg && (rsv_addr_reg == req_addr[PLEN-1:RSV_LSB]);
    assign dword     = (size_reg == SIZE_DWORD);

    assign old_word  = addr_reg[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
    assign old_val   = dword ? bus.mem_rdata : {{32{old_word[31]}}, old_word};

    assign unused_bits = ^{req.operand_a[63:PLEN], addr_reg[1:0], bus.snoop_addr[RSV_LSB-1:0]};

    amo_alu u_alu (
        .op      (op_reg),
        .size    (size_reg),
        .old_val (old_val),
        .operand (operand_reg),
        .new_val (alu_val)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            op_reg        <= AMO_NONE;
            size_reg      <= '0;
            addr_reg      <= '0;
            operand_reg   <= '0;
            wdata_reg     <= '0;
            pending_reg   <= '0;
            result_reg    <= '0;
            rsv_valid_reg <= 1'b0;
            rsv_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            size_reg      <= size_next;
            addr_reg      <= addr_next;
            operand_reg   <= operand_next;
            wdata_reg     <= wdata_next;
            pending_reg   <= pending_next;
            result_reg    <= result_next;
            rsv_valid_reg <= rsv_valid_next;
            rsv_addr_reg  <= rsv_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        size_next      = size_reg;
        addr_next      = addr_reg;
        operand_next   = operand_reg;
        wdata_next     = wdata_reg;
        pending_next   = pending_reg;
        result_next    = result_reg;
        rsv_valid_next = rsv_valid_reg;
        rsv_addr_next  = rsv_addr_reg;

        // Snoop clear comes first so an LR completing this cycle overrides it
        if (bus.snoop_valid && (bus.snoop_addr[PLEN-1:RSV_LSB] == rsv_addr_reg)) begin
            rsv_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (req.req) begin
                    op_next      = req.amo_op;
                    size_next    = req.size;
                    addr_next    = req_addr;
                    operand_next = req.operand_b;
                    if (is_read_op(req.amo_op)) begin
                        state_next = RD_REQ;
                    end else if (req.amo_op == AMO_SC) begin
                        rsv_valid_next = 1'b0;
                        if (rsv_hit) begin
                            wdata_next   = req_dword ? req.operand_b
                                                     : {req.operand_b[31:0], req.operand_b[31:0]};
                            pending_next = '0;
                            state_next   = WR_REQ;
                        end else begin
                            pending_next = AMO_SC_FAIL;
                            state_next   = ACK;
                        end
                    end else begin
                        pending_next = '0;
                        state_next   = ACK;
                    end
                end
            end
            RD_REQ: begin
                if (bus.mem_gnt) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.mem_rvalid) begin
                    pending_next = old_val;
                    wdata_next   = alu_val;
                    if (op_reg == AMO_LR) begin
                        rsv_valid_next = 1'b1;
                        rsv_addr_next  = addr_reg[PLEN-1:RSV_LSB];
                        state_next     = ACK;
                    end else begin
                        state_next = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (bus.mem_gnt) begin
                    if (rsv_addr_reg == addr_reg[PLEN-1:RSV_LSB]) begin
                        rsv_valid_next = 1'b0;
                    end
                    state_next = ACK;
                end
            end
            ACK: begin
                result_next = pending_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port is driven purely from registered state, so it is stable until grant
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if ((state_reg == RD_REQ) || (state_reg == WR_REQ)) begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = (state_reg == WR_REQ);
            bus.mem_addr = {addr_reg[PLEN-1:3], 3'b000};
            bus.mem_be   = dword ? 8'hFF : (addr_reg[2] ? 8'hF0 : 8'h0F);
            if (state_reg == WR_REQ) begin
                bus.mem_wdata = wdata_reg;
            end
        end
    end

    assign bus.amo_resp = '{ack:    (state_reg == ACK),
                            result: ((state_reg == ACK) ? pending_reg : result_reg)};

endmodule
